// File: rtl/fp16_to_int16.sv
// +----------------------------------------------------------------------------+
// | fp16_to_int16: 3-stage valid/ready fp16 -> int16 converter (RNE, saturate) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fp16_to_int16 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic        o_valid,
  output logic [15:0] o_data,
  output logic        o_invalid,
  output logic        o_inexact,
  input  logic        i_ready
);

  localparam logic [15:0]       C_POS_SAT = 16'h7FFF;
  localparam logic [15:0]       C_NEG_SAT = 16'h8000;
  localparam logic signed [5:0] C_BIAS    = 6'sd15;

  // Pipeline control: each stage loads when it is empty or its successor moves.
  logic w_load1, w_load2, w_load3;
  logic r1_valid, r2_valid;

  assign w_load3 = !o_valid | i_ready;
  assign w_load2 = !r2_valid | w_load3;
  assign w_load1 = !r1_valid | w_load2;
  assign o_ready = w_load1;

  // ---------------- S1: classify ----------------
  logic [4:0]        w_exp_field;
  logic [9:0]        w_man;
  logic              w_is_nan, w_is_inf, w_is_zero;
  logic signed [5:0] w_exp_unb;

  assign w_exp_field = i_data[14:10];
  assign w_man       = i_data[9:0];
  assign w_is_nan    = (&w_exp_field) & (|w_man);
  assign w_is_inf    = (&w_exp_field) & ~(|w_man);
  assign w_is_zero   = ~(|w_exp_field);
  assign w_exp_unb   = $signed({1'b0, w_exp_field}) - C_BIAS;

  logic              r1_sign, r1_nan, r1_inf, r1_zero;
  logic signed [5:0] r1_exp;
  logic [10:0]       r1_sig;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_nan   <= 1'b0;
      r1_inf   <= 1'b0;
      r1_zero  <= 1'b0;
      r1_exp   <= '0;
      r1_sig   <= '0;
    end else if (w_load1) begin
      r1_valid <= i_valid;
      if (i_valid) begin
        r1_sign <= i_data[15];
        r1_nan  <= w_is_nan;
        r1_inf  <= w_is_inf;
        r1_zero <= w_is_zero & ~w_is_nan & ~w_is_inf;
        r1_exp  <= w_exp_unb;
        r1_sig  <= {1'b1, w_man};
      end
    end
  end

  // ---------------- S2: align ----------------
  logic [25:0] w_shifted;
  logic [15:0] w_mag;
  logic        w_guard, w_sticky, w_normal, w_ovf;

  assign w_normal = ~(r1_nan | r1_inf | r1_zero);
  // e == 15 overflows except for exactly -32768.
  assign w_ovf    = w_normal & (r1_exp == 6'sd15) & ~(r1_sign & ~(|r1_sig[9:0]));

  always_comb begin
    w_shifted = 26'(r1_sig) << r1_exp[3:0];
    w_mag     = '0;
    w_guard   = 1'b0;
    w_sticky  = 1'b0;
    if (w_normal) begin
      if (!r1_exp[5]) begin
        w_mag    = w_shifted[25:10];
        w_guard  = w_shifted[9];
        w_sticky = |w_shifted[8:0];
      end else if (r1_exp == -6'sd1) begin
        w_guard  = 1'b1;
        w_sticky = |r1_sig[9:0];
      end else begin
        w_sticky = 1'b1;
      end
    end
  end

  logic        r2_sign, r2_nan, r2_sat, r2_guard, r2_sticky;
  logic [15:0] r2_mag;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r2_valid  <= 1'b0;
      r2_sign   <= 1'b0;
      r2_nan    <= 1'b0;
      r2_sat    <= 1'b0;
      r2_guard  <= 1'b0;
      r2_sticky <= 1'b0;
      r2_mag    <= '0;
    end else if (w_load2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sign   <= r1_sign;
        r2_nan    <= r1_nan;
        r2_sat    <= r1_inf | w_ovf;
        r2_guard  <= w_guard;
        r2_sticky <= w_sticky;
        r2_mag    <= w_mag;
      end
    end
  end

  // ---------------- S3: round / sign / saturate ----------------
  logic        w_round_up;
  logic [15:0] w_mag_r;
  logic [15:0] w_result;
  logic        w_invalid, w_inexact;

  assign w_round_up = r2_guard & (r2_sticky | r2_mag[0]);
  // For e <= 14 the rounded magnitude is at most 32752, so 16 bits cannot wrap.
  assign w_mag_r    = r2_mag + {15'd0, w_round_up};

  always_comb begin
    w_result  = r2_sign ? (16'd0 - w_mag_r) : w_mag_r;
    w_invalid = 1'b0;
    w_inexact = r2_guard | r2_sticky;
    if (r2_nan) begin
      w_result  = '0;
      w_invalid = 1'b1;
      w_inexact = 1'b0;
    end else if (r2_sat) begin
      w_result  = r2_sign ? C_NEG_SAT : C_POS_SAT;
      w_invalid = 1'b1;
      w_inexact = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_invalid <= 1'b0;
      o_inexact <= 1'b0;
    end else if (w_load3) begin
      o_valid <= r2_valid;
      if (r2_valid) begin
        o_data    <= w_result;
        o_invalid <= w_invalid;
        o_inexact <= w_inexact;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp16_to_int16.sv
// +----------------------------------------------------------------------------+
// | tb_fp16_to_int16: directed vectors, backpressure and reset sequences       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fp16_to_int16;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [15:0] i_data;
  logic        o_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_invalid;
  logic        o_inexact;
  logic        i_ready;

  int errors = 0;
  int checks = 0;

  fp16_to_int16 dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_ready   (o_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_invalid (o_invalid),
    .o_inexact (o_inexact),
    .i_ready   (i_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] din;
    logic [15:0] dout;
    logic        inv;
    logic        inx;
  } vec_t;

  vec_t vecs[18];
  logic [15:0] ops[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Send one operand into a drained pipeline and wait (bounded) for its result.
  task automatic run_one(input logic [15:0] din, output logic [17:0] got, output bit timeout);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = din;
    @(negedge i_clk);
    i_valid = 1'b0;
    timeout = 1'b1;
    got     = '0;
    for (int k = 0; k < 8; k++) begin
      if (o_valid) begin
        got     = {o_data, o_invalid, o_inexact};
        timeout = 1'b0;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] got;
    bit          tmo;
    int          sent, rcvd, held, last_cyc;
    bit          ready_fell;
    logic        s_ready, s_valid;
    logic [15:0] s_data;

    vecs[0]  = '{16'h3C00, 16'h0001, 1'b0, 1'b0};
    vecs[1]  = '{16'h3800, 16'h0000, 1'b0, 1'b1};
    vecs[2]  = '{16'h3E00, 16'h0002, 1'b0, 1'b1};
    vecs[3]  = '{16'h4100, 16'h0002, 1'b0, 1'b1};
    vecs[4]  = '{16'hBE00, 16'hFFFE, 1'b0, 1'b1};
    vecs[5]  = '{16'h3400, 16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{16'hF800, 16'h8000, 1'b0, 1'b0};
    vecs[7]  = '{16'h7800, 16'h7FFF, 1'b1, 1'b0};
    vecs[8]  = '{16'h77FF, 16'h7FF0, 1'b0, 1'b0};
    vecs[9]  = '{16'hFBFF, 16'h8000, 1'b1, 1'b0};
    vecs[10] = '{16'h7C00, 16'h7FFF, 1'b1, 1'b0};
    vecs[11] = '{16'hFC00, 16'h8000, 1'b1, 1'b0};
    vecs[12] = '{16'h7E00, 16'h0000, 1'b1, 1'b0};
    vecs[13] = '{16'h0001, 16'h0000, 1'b0, 1'b0};
    vecs[14] = '{16'h8000, 16'h0000, 1'b0, 1'b0};
    vecs[15] = '{16'h4500, 16'h0005, 1'b0, 1'b0};
    vecs[16] = '{16'hC500, 16'hFFFB, 1'b0, 1'b0};
    vecs[17] = '{16'h3A00, 16'h0001, 1'b0, 1'b1};

    ops[0] = 16'h3C00;
    ops[1] = 16'h4000;
    ops[2] = 16'h4200;
    ops[3] = 16'h4400;
    ops[4] = 16'h4500;

    // Reset state
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("reset_outputs", {o_valid, o_data, o_invalid, o_inexact}, '0);
    i_rst_n = 1'b1;
    #1;
    check("ready_after_reset", o_ready, 1);

    // Exact latency of a single 1.0
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = 16'h3C00;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("lat_edge1_valid", o_valid, 0);
    @(negedge i_clk);
    check("lat_edge2_valid", o_valid, 0);
    @(negedge i_clk);
    check("lat_edge3_valid", o_valid, 1);
    check("lat_result", {o_data, o_invalid, o_inexact}, {16'h0001, 2'b00});
    @(negedge i_clk);
    check("lat_drained", o_valid, 0);

    // Directed vector table
    for (int i = 0; i < 18; i++) begin
      run_one(vecs[i].din, got, tmo);
      if (tmo) check($sformatf("vec%0d_%h_timeout", i, vecs[i].din), 1, 0);
      else     check($sformatf("vec%0d_%h", i, vecs[i].din), got,
                     {vecs[i].dout, vecs[i].inv, vecs[i].inx});
    end
    repeat (3) @(negedge i_clk);

    // Backpressure: downstream stalled until 6 held-output cycles elapse
    sent = 0; rcvd = 0; held = 0; last_cyc = -1; ready_fell = 1'b0;
    for (int cyc = 0; cyc < 60 && rcvd < 5; cyc++) begin
      @(negedge i_clk);
      i_ready = (held >= 6);
      i_valid = (sent < 5);
      i_data  = (sent < 5) ? ops[sent] : 16'h0000;
      #1;
      s_ready = o_ready;
      s_valid = o_valid;
      s_data  = o_data;
      if (!i_ready && s_valid) begin
        check("stall_hold_data", s_data, 16'h0001);
        held++;
      end
      if (!s_ready && !ready_fell) begin
        ready_fell = 1'b1;
        check("ready_fall_after_ops", sent, 3);
      end
      if (i_ready) check("ready_while_draining", s_ready, 1);
      if (s_valid && i_ready) begin
        check($sformatf("bp_out%0d", rcvd), s_data, 16'(rcvd + 1));
        if (rcvd > 0) check("bp_consecutive", cyc, last_cyc + 1);
        last_cyc = cyc;
        rcvd++;
      end
      if (i_valid && s_ready) sent++;
    end
    check("bp_count", rcvd, 5);
    check("bp_ready_fell", ready_fell, 1);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);

    // Asynchronous reset with three operands in flight
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = ops[k + 1];
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    check("pre_reset_valid", o_valid, 1);
    check("pre_reset_ready", o_ready, 0);
    #1;
    i_rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {o_valid, o_data, o_invalid, o_inexact}, '0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    #1;
    check("post_reset_ready", o_ready, 1);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = 16'h4000;
    @(negedge i_clk);
    i_valid = 1'b0;
    check("rst_lat1", o_valid, 0);
    @(negedge i_clk);
    check("rst_lat2", o_valid, 0);
    @(negedge i_clk);
    check("rst_lat3", o_valid, 1);
    check("rst_result", {o_data, o_invalid, o_inexact}, {16'h0002, 2'b00});
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      check("no_stale_result", o_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp16_to_int16.md
# fp16_to_int16

Pipelined converter from IEEE-754 binary16 to signed 16-bit two's-complement integer. It rounds to nearest, ties to even, and saturates out-of-range values. It is the decode-side counterpart of the fp16 arithmetic blocks in the fp16 pipeline: fp16 results leave the FP datapath through it into integer consumers. It uses the same DAZ convention as the adder and has a three-stage valid/ready pipeline with full backpressure.

## Interface
- No parameters.
- i_clk  input  1  clock, all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input operand valid.
- i_data  input  16  fp16 operand {S[15], E[14:10], M[9:0]}.
- o_ready  output  1  block accepts operand this cycle.
- o_valid  output  1  result valid.
- o_data  output  16  signed integer result.
- o_invalid  output  1  NaN, infinity or overflow; result is saturated or zero.
- o_inexact  output  1  result differs from the input value (rounding only).
- i_ready  input  1  downstream accepts result this cycle.

## Operation
- Handshake: a transfer occurs when valid and ready are both 1 on a clock edge, on both sides.
- Stages S1, S2, S3 each hold a valid bit and payload. S3 drives the o_* outputs directly.
- adv3 = v3 & i_ready.
- Stage k loads when its register is empty or the next stage advances (bubble-collapsing).
- o_ready = !v1 | (!v2 | !v3 | i_ready). It is combinational from i_ready.
- S1 (classify), priority order:
  - E==31, M!=0 → NaN.
  - E==31, M==0 → Inf.
  - E==0 → zero (DAZ: subnormals are exact zero, no flags).
  - Otherwise normal. Register S, e = E−15 (signed 6 bit), sig = {1,M} (11 bit).
- S2 (align):
  - e ≥ 0: form 26-bit sig<<e. Integer part = bits [25:10], guard = bit 9, sticky = |bits[8:0].
  - e = −1: mag = 0, guard = 1, sticky = |M.
  - e ≤ −2: mag = 0, guard = 0, sticky = 1.
- S3 (round/sign/saturate):
  - round_up = g & (s | mag[0]) (RNE). mag_r = mag + round_up (17 bit).
  - inexact = g | s.
  - Overflow when e == 15, except the exact case S=1, E=30+15? No — except S=1, E=30, M=0, which yields 0x8000 exact.
  - Rounding cannot overflow for e ≤ 14: the largest value is 32752.
  - Result is −mag_r if S, else mag_r.
- Special results:
  - NaN → 0x0000, invalid=1.
  - +Inf or positive overflow → 0x7FFF, invalid=1.
  - −Inf or negative overflow → 0x8000, invalid=1.
  - When invalid=1, inexact is forced to 0.
  - ±0 → 0x0000, no flags.

## Timing
- Latency: 3 cycles from input transfer to o_valid when i_ready stays high.
- Throughput: 1 result per cycle.
- Reset (asynchronous, any cycle): v1=v2=v3=0, o_valid=0, o_data=0, o_invalid=0, o_inexact=0. In-flight operands are discarded.
- After reset release, o_ready=1.
- Stall (o_valid & !i_ready):
  - o_data and flags hold stable.
  - Upstream stages fill.
  - o_ready falls after the third operand is held, i.e. all stages full.
- Simultaneous accept and deliver with a full pipeline: all stages shift. o_ready=1 in that cycle, and no bubble is inserted.
- Order is preserved. No loss, no duplication.
- o_valid must not drop without a transfer.

## Test plan
- Single 0x3C00 (1.0), i_ready=1 → o_valid exactly 3 cycles after accept, o_data=0x0001, flags 0.
- Rounding: 0x3800 (0.5) → 0x0000 inexact; 0x3E00 (1.5) → 0x0002 inexact; 0x4100 (2.5) → 0x0002 inexact; 0xBE00 (−1.5) → 0xFFFE inexact; 0x3400 (0.25) → 0x0000 inexact.
- Range limits:
  - 0xF800 (−32768) → 0x8000, flags 0.
  - 0x7800 (32768) → 0x7FFF invalid.
  - 0x77FF (32752) → 0x7FF0 exact.
  - 0xFBFF → 0x8000 invalid.
- Specials:
  - 0x7C00 → 0x7FFF invalid; 0xFC00 → 0x8000 invalid.
  - 0x7E00 → 0x0000 invalid.
  - 0x0001 and 0x8000 → 0x0000, no flags.
- Backpressure: stream 0x3C00, 0x4000, 0x4200, 0x4400, 0x4500 (1, 2, 3, 4, 5) with i_ready low for 6 cycles after the first result.
  - o_data holds 1 throughout the stall.
  - o_ready deasserts once 3 operands are held.
  - On release the outputs are 1, 2, 3, 4, 5 on consecutive cycles.
- Reset mid-stream: assert i_rst_n=0 with 3 operands in flight.
  - o_valid=0 and outputs are 0 immediately, without waiting for a clock edge.
  - After release, the next operand 0x4000 emerges as 0x0002 after 3 cycles, with no stale results.
